rosc_meas_sequencer: RTL and testbench
======================================

// Module: rosc_meas_sequencer
// PURPOSE
//  Downstream consumer and controller of the three-ring (INV/NAND/NOR) odometer block. Powers and selects one ring,
//  then enables it and waits for it to settle. It then counts rising edges of the ring output over a fixed CLK window.
//  The count is returned through a valid/ready handshake to the readout logic.
//  A single CLK domain is used; ROSC_OUT is asynchronous and is synchronised inside this block.
// PARAMETERS
//  CNT_W       16   width of edge counter / CNT_DATA
//  SETTLE_CYC  64   CLK cycles in PWR_UP (virtual VDD settle), >=1
//  WARM_CYC    32   CLK cycles in WARM (ring running, edges discarded), >=1
//  WIN_CYC     1024 CLK cycles in COUNT (gate window), >=1
// PORTS
//  CLK            in   1      block clock; f_CLK >= 4x f(ROSC_OUT)
//  RST_N          in   1      asynchronous, active-low reset
//  START_MEAS     in   1      1-cycle request; sampled only in IDLE
//  ROSC_SEL       in   2      0=INV 1=NAND 2=NOR 3=illegal; captured with START_MEAS
//  ABORT          in   1      level; forces IDLE from any state
//  ROSC_OUT       in   1      asynchronous ring output (OUT of odometer block)
//  EN_POWER_ROSC  out  1      ring power enable
//  MEAS_STRESS    out  1      measurement-mode power switch control
//  EN_ROSC        out  1      closes the selected ring loop
//  SEL_INV/SEL_NAND/SEL_NOR out 1 each  one-hot ring select
//  BUSY           out  1      1 in PWR_UP, WARM, COUNT
//  CNT_VALID      out  1      result available
//  CNT_READY      in   1      consumer accepts result
//  CNT_DATA       out  CNT_W  edge count
//  CNT_OVF        out  1      counter saturated during the window
//  SEL_ERR        out  1      sticky: ROSC_SEL=3 requested; cleared by next legal START_MEAS
// BEHAVIOUR
//  Reset: every output is 0, the FSM is in IDLE, and the counters and sync flops are cleared.
//  FSM: IDLE -> PWR_UP -> WARM -> COUNT -> DONE -> IDLE.
//  IDLE: if START_MEAS=1 and ROSC_SEL<3, latch the select and go to PWR_UP on the next edge.
//        If ROSC_SEL=3, set SEL_ERR and stay in IDLE.
//  PWR_UP: EN_POWER_ROSC=1, MEAS_STRESS=1, SEL_x one-hot, EN_ROSC=0. Lasts exactly SETTLE_CYC cycles.
//  WARM: as PWR_UP plus EN_ROSC=1. Lasts exactly WARM_CYC cycles; synchronised edges are ignored.
//  COUNT: as WARM. Lasts exactly WIN_CYC cycles. The counter clears on entry.
//         Each cycle with a synchronised rising edge adds 1, including edges in the first and last COUNT cycles.
//  Saturation: at all-ones the counter holds and CNT_OVF=1.
//  DONE: EN_ROSC, EN_POWER_ROSC, MEAS_STRESS and SEL_x are all 0. CNT_VALID=1; CNT_DATA and CNT_OVF are stable.
//        On CNT_VALID&CNT_READY go to IDLE and drop CNT_VALID on the next edge.
//  Latency: START_MEAS at edge N gives CNT_VALID=1 after edge N+SETTLE_CYC+WARM_CYC+WIN_CYC+1.
//  START_MEAS outside IDLE is ignored, including in DONE before the handshake completes.
//  ABORT=1 in any state: next edge goes to IDLE and all ring controls go to 0.
//      No result is produced; CNT_VALID drops if it was set.
//      ABORT takes priority over START_MEAS and over a simultaneous handshake.
//  The edge synchroniser and detector keep running in every state; the edge pulse is gated by the COUNT state.
//  Reset asserted mid-measurement: outputs go to 0 immediately (asynchronously). There is no partial result.
//  Phase counter: one shared down-counter of width clog2(max(SETTLE,WARM,WIN)+1), reloaded on each state entry.
// STRUCTURE
//  Package rosc_meas_pkg holds:
//    - the state enum (IDLE, PWR_UP, WARM, COUNT, DONE);
//    - the ROSC_SEL encodings ROSC_INV=0, ROSC_NAND=1, ROSC_NOR=2;
//    - a function sel2onehot.
//  Sub-module rosc_edge_sync: two-flop synchroniser, a third flop, and rise = s2 & ~s3.
//    All three flops use async reset to 0.
//  Top level contains the FSM, the phase counter, the saturating edge counter and the result register.
// TESTING
//  1. ROSC_OUT at f_CLK/8, SEL=1, SETTLE=4, WARM=4, WIN=64: CNT_DATA=8 +/-1.
//     SEL_NAND is the only select high; CNT_VALID rises at cycle 73.
//  2. SEL=3: SEL_ERR=1, BUSY stays 0, no ring control toggles.
//     A following SEL=0 request clears SEL_ERR and measures normally.
//  3. CNT_W=4, ROSC_OUT at f_CLK/4, WIN=256: CNT_DATA=4'hF and CNT_OVF=1.
//  4. CNT_READY held 0 for 50 cycles in DONE: CNT_DATA stays stable and a START_MEAS pulse is ignored.
//     Raising CNT_READY returns the FSM to IDLE on the next edge.
//  5. ABORT in cycle 10 of COUNT: IDLE next cycle, all outputs 0, no CNT_VALID.
//     A fresh START then gives a count with no carry-over from the aborted run.
//  6. RST_N pulsed low mid-WARM: outputs 0 asynchronously.
//     After release the FSM stays in IDLE until START_MEAS.

Source files
------------

// File: rtl/rosc_meas_pkg.sv
// Shared types and helpers for the ring-oscillator measurement sequencer.
package rosc_meas_pkg;

    // Sequencer phases, in the order a measurement walks through them.
    typedef enum logic [2:0] {
        StIdle,
        StPwrUp,
        StWarm,
        StCount,
        StDone
    } meas_state_e;

    // ROSC_SEL encodings; 3 is the illegal code.
    localparam logic [1:0] ROSC_INV  = 2'd0;
    localparam logic [1:0] ROSC_NAND = 2'd1;
    localparam logic [1:0] ROSC_NOR  = 2'd2;

    // Returns {nor, nand, inv}; the illegal code selects nothing.
    function automatic logic [2:0] sel2onehot(input logic [1:0] sel);
        logic [2:0] oh;
        oh = 3'b000;
        case (sel)
            ROSC_INV:  oh = 3'b001;
            ROSC_NAND: oh = 3'b010;
            ROSC_NOR:  oh = 3'b100;
            default:   oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/rosc_edge_sync.sv
// Brings the asynchronous ring output into the clk domain and flags its rising edges.
module rosc_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic s1_q, s2_q, s3_q;

    // Two-flop synchroniser plus one delay flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/rosc_meas_sequencer.sv
// Powers, selects and enables one ring, lets it settle, counts its rising edges over a
// fixed clk window and hands the count to the readout logic through valid/ready.
module rosc_meas_sequencer
    import rosc_meas_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned SETTLE_CYC = 64,
    parameter int unsigned WARM_CYC   = 32,
    parameter int unsigned WIN_CYC    = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_meas,
    input  logic [1:0]       rosc_sel,
    input  logic             abort,
    input  logic             rosc_out,
    output logic             en_power_rosc,
    output logic             meas_stress,
    output logic             en_rosc,
    output logic             sel_inv,
    output logic             sel_nand,
    output logic             sel_nor,
    output logic             busy,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic [CNT_W-1:0] cnt_data,
    output logic             cnt_ovf,
    output logic             sel_err
);

    localparam int unsigned MAX_SW  = (SETTLE_CYC > WARM_CYC) ? SETTLE_CYC : WARM_CYC;
    localparam int unsigned MAX_CYC = (MAX_SW > WIN_CYC) ? MAX_SW : WIN_CYC;
    localparam int unsigned PH_W    = $clog2(MAX_CYC + 1);

    meas_state_e      state_q, state_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       sel_q, sel_d;
    logic             sel_err_q, sel_err_d;
    logic             ph_load;
    logic [PH_W-1:0]  ph_load_val;
    logic             rise;
    logic             idle_start;
    logic [2:0]       sel_oh;

    rosc_edge_sync u_edge_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (rosc_out),
        .rise     (rise)
    );

    // A start request is only honoured in IDLE and never alongside abort.
    assign idle_start = (state_q == StIdle) && start_meas && !abort;

    // Next-state logic; each phase reloads the shared down-counter on entry.
    always_comb begin
        state_d     = state_q;
        ph_load     = 1'b0;
        ph_load_val = '0;
        case (state_q)
            StIdle: begin
                if (start_meas && (rosc_sel != 2'd3)) begin
                    state_d     = StPwrUp;
                    ph_load     = 1'b1;
                    ph_load_val = PH_W'(SETTLE_CYC - 1);
                end
            end
            StPwrUp: begin
                if (ph_q == '0) begin
                    state_d     = StWarm;
                    ph_load     = 1'b1;
                    ph_load_val = PH_W'(WARM_CYC - 1);
                end
            end
            StWarm: begin
                if (ph_q == '0) begin
                    state_d     = StCount;
                    ph_load     = 1'b1;
                    ph_load_val = PH_W'(WIN_CYC - 1);
                end
            end
            StCount: begin
                if (ph_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (cnt_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StIdle;
        end
    end

    // Phase counter, select latch, sticky select error and saturating edge counter.
    always_comb begin
        ph_d      = ph_q;
        sel_d     = sel_q;
        sel_err_d = sel_err_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;

        if (ph_load) begin
            ph_d = ph_load_val;
        end else if (ph_q != '0) begin
            ph_d = ph_q - PH_W'(1);
        end

        if (idle_start) begin
            sel_err_d = (rosc_sel == 2'd3);
            if (rosc_sel != 2'd3) begin
                sel_d = rosc_sel;
            end
        end

        if ((state_d == StCount) && (state_q != StCount)) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if ((state_q == StCount) && rise) begin
            // Hold at all-ones and remember that an edge was lost.
            if (&cnt_q) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ph_q      <= '0;
            sel_q     <= ROSC_INV;
            sel_err_q <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            sel_q     <= sel_d;
            sel_err_q <= sel_err_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    // Outputs decode from the state register so reset clears them without a clock.
    always_comb begin
        busy          = (state_q == StPwrUp) || (state_q == StWarm) || (state_q == StCount);
        en_power_rosc = busy;
        meas_stress   = busy;
        en_rosc       = (state_q == StWarm) || (state_q == StCount);
        sel_oh        = busy ? sel2onehot(sel_q) : 3'b000;
        sel_inv       = sel_oh[0];
        sel_nand      = sel_oh[1];
        sel_nor       = sel_oh[2];
        cnt_valid     = (state_q == StDone);
        // Partial counts from an aborted window never reach the port.
        cnt_data      = cnt_valid ? cnt_q : '0;
        cnt_ovf       = cnt_valid & ovf_q;
        sel_err       = sel_err_q;
    end

endmodule

// File: tb/tb_rosc_meas_sequencer.sv
// Directed bench for rosc_meas_sequencer: a short-window instance for the main flow and a
// narrow-counter instance for saturation.
module tb_rosc_meas_sequencer;

    // Control bundle order: {en_power, stress, en_rosc, inv, nand, nor, busy, valid}.
    localparam logic [7:0] CTL_IDLE     = 8'b0000_0000;
    localparam logic [7:0] CTL_PWR_NAND = 8'b1100_1010;
    localparam logic [7:0] CTL_RUN_NAND = 8'b1110_1010;
    localparam logic [7:0] CTL_PWR_INV  = 8'b1101_0010;
    localparam logic [7:0] CTL_RUN_NOR  = 8'b1110_0110;
    localparam logic [7:0] CTL_DONE     = 8'b0000_0001;

    logic        clk;
    logic        rst_n;
    logic        start, abort, ready, rosc_a;
    logic [1:0]  sel;
    logic        en_power, meas_stress, en_rosc, sel_inv, sel_nand, sel_nor, busy, cnt_valid;
    logic [15:0] cnt_data;
    logic        cnt_ovf, sel_err;
    logic [7:0]  ctl;

    logic        start_b, abort_b, ready_b, rosc_b;
    logic [1:0]  sel_b;
    logic        en_power_b, meas_stress_b, en_rosc_b, sel_inv_b, sel_nand_b, sel_nor_b;
    logic        busy_b, cnt_valid_b;
    logic [3:0]  cnt_data_b;
    logic        cnt_ovf_b, sel_err_b;
    logic [7:0]  ctl_b;

    int n_pass;
    int n_checks;

    assign ctl   = {en_power, meas_stress, en_rosc, sel_inv, sel_nand, sel_nor, busy, cnt_valid};
    assign ctl_b = {en_power_b, meas_stress_b, en_rosc_b, sel_inv_b, sel_nand_b, sel_nor_b,
                    busy_b, cnt_valid_b};

    rosc_meas_sequencer #(
        .CNT_W      (16),
        .SETTLE_CYC (4),
        .WARM_CYC   (4),
        .WIN_CYC    (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_meas    (start),
        .rosc_sel      (sel),
        .abort         (abort),
        .rosc_out      (rosc_a),
        .en_power_rosc (en_power),
        .meas_stress   (meas_stress),
        .en_rosc       (en_rosc),
        .sel_inv       (sel_inv),
        .sel_nand      (sel_nand),
        .sel_nor       (sel_nor),
        .busy          (busy),
        .cnt_valid     (cnt_valid),
        .cnt_ready     (ready),
        .cnt_data      (cnt_data),
        .cnt_ovf       (cnt_ovf),
        .sel_err       (sel_err)
    );

    rosc_meas_sequencer #(
        .CNT_W      (4),
        .SETTLE_CYC (4),
        .WARM_CYC   (4),
        .WIN_CYC    (256)
    ) dut_ovf (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_meas    (start_b),
        .rosc_sel      (sel_b),
        .abort         (abort_b),
        .rosc_out      (rosc_b),
        .en_power_rosc (en_power_b),
        .meas_stress   (meas_stress_b),
        .en_rosc       (en_rosc_b),
        .sel_inv       (sel_inv_b),
        .sel_nand      (sel_nand_b),
        .sel_nor       (sel_nor_b),
        .busy          (busy_b),
        .cnt_valid     (cnt_valid_b),
        .cnt_ready     (ready_b),
        .cnt_data      (cnt_data_b),
        .cnt_ovf       (cnt_ovf_b),
        .sel_err       (sel_err_b)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rings locked to the clk time base, edges kept off the clock edges:
    // rosc_a = f_clk/8 (8 rises per 64 cycles), rosc_b = f_clk/4.
    initial begin
        rosc_a = 1'b0;
        #2;
        forever #40 rosc_a = ~rosc_a;
    end

    initial begin
        rosc_b = 1'b0;
        #2;
        forever #20 rosc_b = ~rosc_b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        n_pass   = 0;
        n_checks = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        sel      = 2'd0;
        abort    = 1'b0;
        ready    = 1'b0;
        start_b  = 1'b0;
        sel_b    = 2'd0;
        abort_b  = 1'b0;
        ready_b  = 1'b0;

        // Reset state.
        step(3);
        check("reset_ctl", 32'(ctl), 32'(CTL_IDLE));
        check("reset_data", 32'(cnt_data), 32'd0);
        check("reset_sel_err", 32'(sel_err), 32'd0);
        check("reset_ctl_b", 32'(ctl_b), 32'(CTL_IDLE));
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", 32'(ctl), 32'(CTL_IDLE));

        // NAND ring, full measurement; start sampled at edge 1, DONE after edge 73.
        sel   = 2'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_pwr_up_first", 32'(ctl), 32'(CTL_PWR_NAND));
        step(3);
        check("t1_pwr_up_last", 32'(ctl), 32'(CTL_PWR_NAND));
        tick();
        check("t1_warm", 32'(ctl), 32'(CTL_RUN_NAND));
        step(67);
        check("t1_count_last", 32'(ctl), 32'(CTL_RUN_NAND));
        tick();
        check("t1_done", 32'(ctl), 32'(CTL_DONE));
        check("t1_count", 32'(cnt_data), 32'd8);
        check("t1_ovf", 32'(cnt_ovf), 32'd0);

        // Held in DONE for 50 cycles with an illegal start pulse that must be ignored.
        step(20);
        sel   = 2'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        step(29);
        check("t4_still_done", 32'(ctl), 32'(CTL_DONE));
        check("t4_data_stable", 32'(cnt_data), 32'd8);
        check("t4_no_sel_err", 32'(sel_err), 32'd0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("t4_idle_after_hs", 32'(ctl), 32'(CTL_IDLE));
        check("t4_data_cleared", 32'(cnt_data), 32'd0);

        // Illegal select, then a legal INV request that clears the error.
        sel   = 2'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_sel_err_set", 32'(sel_err), 32'd1);
        check("t2_no_ctl", 32'(ctl), 32'(CTL_IDLE));
        step(5);
        check("t2_still_idle", 32'(ctl), 32'(CTL_IDLE));
        check("t2_sel_err_sticky", 32'(sel_err), 32'd1);
        sel   = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_sel_err_clear", 32'(sel_err), 32'd0);
        check("t2_pwr_inv", 32'(ctl), 32'(CTL_PWR_INV));
        step(72);
        check("t2_done", 32'(ctl), 32'(CTL_DONE));
        check("t2_count", 32'(cnt_data), 32'd8);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("t2_idle", 32'(ctl), 32'(CTL_IDLE));

        // Abort in COUNT cycle 10 (COUNT starts after edge 9), then a clean rerun.
        sel   = 2'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        step(17);
        check("t5_counting", 32'(ctl), 32'(CTL_RUN_NAND));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_abort_idle", 32'(ctl), 32'(CTL_IDLE));
        check("t5_abort_data", 32'(cnt_data), 32'd0);
        step(70);
        check("t5_no_result", 32'(ctl), 32'(CTL_IDLE));
        start = 1'b1;
        tick();
        start = 1'b0;
        step(72);
        check("t5_rerun_done", 32'(ctl), 32'(CTL_DONE));
        check("t5_rerun_count", 32'(cnt_data), 32'd8);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("t5_rerun_idle", 32'(ctl), 32'(CTL_IDLE));

        // Reset pulsed mid-WARM: outputs clear between clock edges.
        sel   = 2'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        step(5);
        check("t6_warm_nor", 32'(ctl), 32'(CTL_RUN_NOR));
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_async_clear", 32'(ctl), 32'(CTL_IDLE));
        step(2);
        rst_n = 1'b1;
        step(10);
        check("t6_stays_idle", 32'(ctl), 32'(CTL_IDLE));
        sel   = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_restart", 32'(ctl), 32'(CTL_PWR_INV));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6_abort_pwr_up", 32'(ctl), 32'(CTL_IDLE));

        // Narrow counter: 64 edges into a 4-bit counter saturates at 4'hF.
        sel_b   = 2'd1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        step(263);
        check("t3_count_last", 32'(ctl_b), 32'(CTL_RUN_NAND));
        tick();
        check("t3_done", 32'(ctl_b), 32'(CTL_DONE));
        check("t3_sat_data", 32'(cnt_data_b), 32'hF);
        check("t3_ovf", 32'(cnt_ovf_b), 32'd1);
        ready_b = 1'b1;
        tick();
        ready_b = 1'b0;
        check("t3_idle", 32'(ctl_b), 32'(CTL_IDLE));
        check("t3_ovf_cleared", 32'(cnt_ovf_b), 32'd0);
        check("t3_sel_err", 32'(sel_err_b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
